// File: rtl/seq_adder.sv
// Slice-serial adder: sums A+B+cin one SLICE-bit chunk per cycle and
// publishes S with carry/negative/zero/overflow flags on a one-cycle done pulse.
module seq_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             N,
  output logic             Z,
  output logic             V
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, shadow, shadow_nx;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [SLICE:0]   slice_sum;
  logic             last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = CALC;
      end
      CALC: if (last) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    slice_sum = {1'b0, a_q[idx*SLICE +: SLICE]}
              + {1'b0, b_q[idx*SLICE +: SLICE]}
              + (SLICE+1)'(carry);
    last      = (int'(idx) == NSL - 1);
    shadow_nx = shadow;
    shadow_nx[idx*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

  // Result and flags load on the edge that enters DONE, so they are already
  // valid during the done cycle and untouched at every other edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      S      <= '0;
      cout   <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b0;
      V      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q    <= A;
          b_q    <= B;
          carry  <= cin;
          idx    <= '0;
          shadow <= '0;
        end
        CALC: begin
          shadow <= shadow_nx;
          carry  <= slice_sum[SLICE];
          idx    <= idx + IW'(1);
          if (last) begin
            S    <= shadow_nx;
            cout <= slice_sum[SLICE];
            N    <= shadow_nx[WIDTH-1];
            Z    <= (shadow_nx == '0);
            V    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (shadow_nx[WIDTH-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: directed cases from the test plan plus
// random adds compared against a plain 33-bit arithmetic reference.
module tb_seq_adder;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NSL   = WIDTH / SLICE;
  localparam int LAT   = NSL + 1;

  logic             clk = 1'b0;
  logic             rst_n, start, cin;
  logic [WIDTH-1:0] A, B, S;
  logic             ready, done, cout, N, Z, V;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [WIDTH-1:0] exp_s;
  logic             exp_c, exp_n, exp_z, exp_v;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .cin(cin),
    .ready(ready), .done(done), .S(S), .cout(cout), .N(N), .Z(Z), .V(V)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    logic [WIDTH:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    exp_s = full[WIDTH-1:0];
    exp_c = full[WIDTH];
    exp_n = exp_s[WIDTH-1];
    exp_z = (exp_s == 0);
    exp_v = (a[WIDTH-1] == b[WIDTH-1]) && (exp_s[WIDTH-1] != a[WIDTH-1]);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".S"},    64'(S),    64'(exp_s));
    check({tag, ".cout"}, 64'(cout), 64'(exp_c));
    check({tag, ".N"},    64'(N),    64'(exp_n));
    check({tag, ".Z"},    64'(Z),    64'(exp_z));
    check({tag, ".V"},    64'(V),    64'(exp_v));
  endtask

  // One full add: accept, watch CALC (result must hold), then check done cycle.
  task automatic run_add(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic c, input bit busy);
    int lat;
    bit seen;
    check({tag, ".ready_idle"}, 64'(ready), 64'd1);
    A = a; B = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; cin = 1'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int j = 0; j < 20; j++) begin
      if (done) begin
        seen = 1'b1;
        lat  = j + 1;
        break;
      end
      check({tag, ".ready_busy"}, 64'(ready), 64'd0);
      check({tag, ".hold_S"},     64'(S),     64'(exp_s));
      if (busy && j == 1) begin
        start = 1'b1; A = 32'h100; B = 32'h200; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, ".latency"}, 64'(lat), 64'(LAT));
      model(a, b, c);
      check_outputs(tag);
      check({tag, ".ready_in_done"}, 64'(ready), 64'd0);
      tick();
      check({tag, ".done_pulse"}, 64'(done),  64'd0);
      check({tag, ".ready_back"}, 64'(ready), 64'd1);
      check_outputs({tag, ".after"});
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      check({tag, ".no_done"}, 64'(done), 64'd0);
      tick();
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; cin = 1'b0;
    exp_s = '0; exp_c = 1'b0; exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset.ready", 64'(ready), 64'd1);
    check("reset.done",  64'(done),  64'd0);
    check_outputs("reset");
    expect_quiet("reset_idle", 4);

    run_add("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_add("sovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_add("cin_edge", 32'h1234_5678, 32'h0000_000F, 1'b1, 1'b0);
    run_add("busy",     32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
    expect_quiet("busy_after", 8);
    check("busy.S_final", 64'(S), 64'h3);

    // Abort an operation two cycles after it was accepted.
    A = 32'hDEAD_BEEF; B = 32'h1111_1111; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_s = '0; exp_c = 1'b0; exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
    check("abort.ready", 64'(ready), 64'd1);
    check_outputs("abort");
    expect_quiet("abort_idle", 6);
    check_outputs("abort.still");
    run_add("post_abort", 32'd5, 32'd7, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      case ($urandom_range(0, 5))
        0: rb = ~ra;
        1: begin ra[WIDTH-1] = 1'b0; rb[WIDTH-1] = 1'b0; end
        2: begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
        default: ;
      endcase
      run_add("rand", ra, rb, rc, bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
